// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register-dependency, mult/div and eret stalls.
// Optional per-cycle stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        D_md_use,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        D_eret,
    input  logic        E_mtc0_epc,
    input  logic        M_mtc0_epc,
    input  logic        req,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
`ifdef HAZARD_STALL_CNT_EN
    output logic        md_busy,
    output logic [31:0] stall_cnt
`else
    output logic        md_busy
`endif
);

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    md_state_t  state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    logic rs_stall, rt_stall, reg_stall, md_stall, eret_stall, stall;

    // A Tuse of 3 marks an unused operand, so it can never create a dependency.
    assign rs_stall = (D_rs != 5'd0) && (D_Tuse_rs != 2'd3) &&
                      (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                       ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));
    assign rt_stall = (D_rt != 5'd0) && (D_Tuse_rt != 2'd3) &&
                      (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                       ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));
    assign reg_stall = rs_stall | rt_stall;

    assign md_busy    = E_md_start | (state_q == MD_BUSY);
    assign md_stall   = D_md_use & md_busy;
    assign eret_stall = D_eret & (E_mtc0_epc | M_mtc0_epc);

    assign stall = (reg_stall | md_stall | eret_stall) & ~req;
    assign F_en  = ~stall;
    assign D_en  = ~stall;
    assign E_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A new start (even while busy) reloads; otherwise count down and leave
    // BUSY on the cycle the counter hits zero. A flush request blocks starts
    // but never aborts an operation already counting.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (E_md_start && !req) begin
            state_d  = MD_BUSY;
            md_cnt_d = E_md_div ? 4'd10 : 4'd5;
        end else if (state_q == MD_BUSY) begin
            if (md_cnt_q <= 4'd1) begin
                state_d  = MD_IDLE;
                md_cnt_d = 4'd0;
            end else begin
                md_cnt_d = md_cnt_q - 4'd1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: D_rs, D_rt  input  5 each  source register numbers of the instruction in D.
REQ-004 SHALL have ports: D_Tuse_rs, D_Tuse_rt  input  2 each  cycles until operand is consumed; 3 = operand unused.
REQ-005 SHALL have ports: E_A3, M_A3  input  5 each  destination register of the instruction in E / M; 0 = none.
REQ-006 SHALL have ports: E_Tnew, M_Tnew  input  2 each  cycles until the E / M result is forwardable.
REQ-007 SHALL have port: D_md_use  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have ports: E_md_start  input  1  mult/div issuing in E this cycle; E_md_div  input  1  issuing op is a divide.
REQ-009 SHALL have ports: D_eret  input  1  eret in D; E_mtc0_epc, M_mtc0_epc  input  1 each  mtc0 to EPC in E / M.
REQ-010 SHALL have port: req  input  1  exception/interrupt flush request from CP0.
REQ-011 SHALL have ports: F_en, D_en  output  1 each  PC and F/D register enable; E_clr  output  1  insert bubble into D/E register.
REQ-012 SHALL have port: md_busy  output  1  multiply/divide unit occupied.

Function
REQ-013 SHALL assert reg_stall when, for rs (and identically rt), rs!=0 and ((rs==E_A3 and E_Tnew>D_Tuse_rs) or (rs==M_A3 and M_Tnew>D_Tuse_rs)); Tuse=3 never stalls.
REQ-014 SHALL contain a 2-state MDU FSM: MD_IDLE, MD_BUSY, with a 4-bit down-counter md_cnt.
REQ-015 SHALL, on E_md_start with req=0, load md_cnt=5 (E_md_div=0) or 10 (E_md_div=1) and enter MD_BUSY; start in MD_BUSY reloads the counter.
REQ-016 SHALL in MD_BUSY decrement md_cnt each cycle and return to MD_IDLE in the cycle md_cnt reaches 0.
REQ-017 SHALL drive md_busy = E_md_start | (state==MD_BUSY), combinationally.
REQ-018 SHALL assert md_stall = D_md_use & md_busy.
REQ-019 SHALL assert eret_stall = D_eret & (E_mtc0_epc | M_mtc0_epc).
REQ-020 SHALL form stall = (reg_stall | md_stall | eret_stall) & ~req; outputs F_en = D_en = ~stall, E_clr = stall, all combinational (zero latency).
REQ-021 SHALL, when req=1, force F_en=1, D_en=1, E_clr=0 (flush owned by pipeline registers) and ignore E_md_start; an in-flight MD_BUSY operation SHALL continue counting, not be aborted.
REQ-022 SHALL treat simultaneous reg/md/eret stall conditions as a single stall (no priority effects).

Reset
REQ-023 SHALL on reset set state=MD_IDLE, md_cnt=0; reset dominates E_md_start and req in the same cycle.
REQ-024 SHALL, during and after reset with inputs zero, output F_en=1, D_en=1, E_clr=0, md_busy=0.

Configuration
REQ-025 SHALL, with macro HAZARD_STALL_CNT_EN defined, add output stall_cnt (32-bit) incrementing once per cycle with stall=1, wrapping 0xFFFFFFFF->0, cleared to 0 on reset.
REQ-026 SHALL, without HAZARD_STALL_CNT_EN, omit the stall_cnt port and counter entirely; all other behaviour identical.

Verification
REQ-027 Load-use: E_A3=8, E_Tnew=2, D_rs=8, D_Tuse_rs=1 -> F_en=0, D_en=0, E_clr=1; same with D_rs=0 -> no stall.
REQ-028 Forwardable: M_A3=9, M_Tnew=0, D_rt=9, D_Tuse_rt=0 -> no stall; M_Tnew=1 -> stall.
REQ-029 Divide: E_md_start=1, E_md_div=1 at cycle 0, D_md_use=1 held -> md_busy=1 cycles 0..10, stall ends cycle 11; mult gives cycles 0..5.
REQ-030 Exception: req=1 while reg_stall condition true -> F_en=1, E_clr=0; req with E_md_start -> md_busy stays 0 next cycle.
REQ-031 eret: D_eret=1, M_mtc0_epc=1 -> stall 1 cycle; then M_mtc0_epc=0 -> released.
REQ-032 Reset mid-divide: reset at md_cnt=6 -> next cycle md_busy=0, and (HAZARD_STALL_CNT_EN) stall_cnt=0.
